// File: rtl/serial_magnitude_comparator.sv
// Purpose: multi-cycle WIDTH-bit magnitude compare, MSB-first, DIGIT bits per cycle, early exit.
// Latency: done in cycle j+1 after accept (j = index of deciding digit, 1..N); worst case N+1.
// Backpressure: none; start is accepted only in IDLE, ignored (not queued) while busy.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int N  = WIDTH / DIGIT;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0]    PTR_TOP  = PW'(N - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    // Current digit of each operand register, selected by the scan pointer.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;

    assign a_sh  = a_q >> (ptr_q * DIGIT);
    assign b_sh  = b_q >> (ptr_q * DIGIT);
    assign dig_a = a_sh[DIGIT-1:0];
    assign dig_b = b_sh[DIGIT-1:0];

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ptr_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ptr_q   <= ptr_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    // Next-state: accept in IDLE, scan digits MSB-first, exit on first difference or last digit.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ptr_d   = ptr_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit of both operands maps two's-complement
                    // order onto unsigned order, so the scan itself stays unsigned.
                    a_d     = is_signed ? (a ^ MSB_MASK) : a;
                    b_d     = is_signed ? (b ^ MSB_MASK) : b;
                    ptr_d   = PTR_TOP;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (dig_a > dig_b) begin
                    gt_d    = 1'b1;
                    state_d = DONE;
                end else if (dig_a < dig_b) begin
                    lt_d    = 1'b1;
                    state_d = DONE;
                end else if (ptr_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    ptr_d   = ptr_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state and flags.
    always_comb begin
        busy = (state_q == SCAN) || (state_q == DONE);
        done = (state_q == DONE);
        gt   = gt_q;
        eq   = eq_q;
        lt   = lt_q;
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Randomized and directed bench for serial_magnitude_comparator (8/2 and 4/1 configurations).
// Reference model works on whole-operand integer compares and the highest differing bit.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_serial_magnitude_comparator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       is_signed;
    logic       busy, done, gt, eq, lt;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       is_signed4;
    logic       busy4, done4, gt4, eq4, lt4;

    int n_checks;
    int n_errors;

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .is_signed(is_signed),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    serial_magnitude_comparator #(.WIDTH(4), .DIGIT(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .is_signed(is_signed4),
        .busy(busy4), .done(done4), .gt(gt4), .eq(eq4), .lt(lt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Number of scan cycles: digits from the top down to the one holding the
    // highest differing bit (all N when the operands are equal).
    function automatic int ref_lat(input int x, input int y, input int w, input int d);
        int diff;
        int h;
        diff = (x ^ y) & ((1 << w) - 1);
        if (diff == 0) return w / d;
        h = 0;
        for (int i = 0; i < w; i++)
            if (diff[i]) h = i;
        return w / d - h / d;
    endfunction

    // Expected {gt,eq,lt} from a plain integer compare.
    function automatic logic [2:0] ref_rel(input int x, input int y, input int w, input logic s);
        int xv;
        int yv;
        xv = x & ((1 << w) - 1);
        yv = y & ((1 << w) - 1);
        if (s && xv[w-1]) xv = xv - (1 << w);
        if (s && yv[w-1]) yv = yv - (1 << w);
        if (xv > yv) return 3'b100;
        if (xv < yv) return 3'b001;
        return 3'b010;
    endfunction

    // One full compare on the 8-bit instance; called at a falling edge with the DUT idle.
    task automatic run_cmp(input logic [7:0] x, input logic [7:0] y, input logic s, input string tag);
        int exp_done;
        int cyc;
        logic [2:0] rel;
        exp_done = ref_lat(int'(x), int'(y), 8, 2) + 1;
        rel      = ref_rel(int'(x), int'(y), 8, s);
        start = 1'b1; a = x; b = y; is_signed = s;
        @(negedge clk);
        // Scrambled operands after accept must not influence the result.
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
        chk({tag, "_busy_c1"}, busy, 1);
        chk({tag, "_flags_c1"}, {gt, eq, lt}, 3'b000);
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_cycle"}, cyc, exp_done);
        chk({tag, "_flags"}, {gt, eq, lt}, rel);
        chk({tag, "_busy_done"}, busy, 1);
        @(negedge clk);
        chk({tag, "_idle"}, {busy, done}, 2'b00);
        chk({tag, "_hold"}, {gt, eq, lt}, rel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] x4;
        logic [3:0] y4;
        logic       s;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; is_signed4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outs", {busy, done, gt, eq, lt}, 5'b0);
        chk("reset_outs4", {busy4, done4, gt4, eq4, lt4}, 5'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_cmp(8'hA5, 8'h35, 1'b0, "a5_35");
        run_cmp(8'h5C, 8'h5D, 1'b0, "5c_5d");
        run_cmp(8'h3C, 8'h3C, 1'b0, "eq_u");
        run_cmp(8'h3C, 8'h3C, 1'b1, "eq_s");
        run_cmp(8'h80, 8'h7F, 1'b1, "80_7f_s");
        run_cmp(8'h80, 8'h7F, 1'b0, "80_7f_u");
        run_cmp(8'hFF, 8'h01, 1'b1, "m1_1_s");

        // Handshake: starts during SCAN and DONE are ignored, start right after DONE is taken.
        start = 1'b1; a = 8'h01; b = 8'h02; is_signed = 1'b0;
        @(negedge clk);                                   // cycle 1
        start = 1'b0;
        @(negedge clk);                                   // cycle 2
        start = 1'b1; a = 8'hF0; b = 8'h00;
        @(negedge clk);                                   // cycle 3
        start = 1'b0;
        chk("hs_busy_c3", busy, 1);
        @(negedge clk);                                   // cycle 4
        chk("hs_nodone_c4", done, 0);
        @(negedge clk);                                   // cycle 5
        chk("hs_done_c5", done, 1);
        chk("hs_flags_c5", {gt, eq, lt}, 3'b001);
        start = 1'b1; a = 8'hF0; b = 8'h00;
        @(negedge clk);                                   // cycle 6
        chk("hs_idle_c6", {busy, done}, 2'b00);
        chk("hs_hold_c6", {gt, eq, lt}, 3'b001);
        start = 1'b1; a = 8'h09; b = 8'h02;
        @(negedge clk);                                   // cycle 7
        start = 1'b0;
        chk("hs_clear_c7", {gt, eq, lt}, 3'b000);
        chk("hs_busy_c7", busy, 1);
        cyc = 7;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk("hs_done2_cycle", cyc, 6 + ref_lat(9, 2, 8, 2) + 1);
        chk("hs_flags2", {gt, eq, lt}, 3'b100);
        @(negedge clk);
        @(negedge clk);
        chk("hs_single_done", done, 0);

        // Reset mid-scan on both instances.
        start = 1'b1; a = 8'h00; b = 8'h00; is_signed = 1'b0;
        start4 = 1'b1; a4 = 4'h0; b4 = 4'h0;
        @(negedge clk);                                   // cycle 1
        start = 1'b0; start4 = 1'b0;
        @(negedge clk);                                   // cycle 2
        @(negedge clk);                                   // cycle 3
        rst_n = 1'b0;
        @(negedge clk);                                   // cycle 4
        chk("rst_mid", {busy, done, gt, eq, lt}, 5'b0);
        chk("rst_mid4", {busy4, done4, gt4, eq4, lt4}, 5'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_done", {busy, done}, 2'b00);
        end

        // 4-bit, 1-bit-digit instance.
        start4 = 1'b1; a4 = 4'b1010; b4 = 4'b1011; is_signed4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        cyc = 1;
        while (!done4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("w4_done_cycle", cyc, 5);
        chk("w4_flags", {gt4, eq4, lt4}, 3'b001);
        @(negedge clk);
        for (int t = 0; t < 40; t++) begin
            x4 = 4'($urandom); y4 = 4'($urandom); s = 1'($urandom);
            start4 = 1'b1; a4 = x4; b4 = y4; is_signed4 = s;
            @(negedge clk);
            start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
            cyc = 1;
            while (!done4 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk("w4r_done_cycle", cyc, ref_lat(int'(x4), int'(y4), 4, 1) + 1);
            chk("w4r_flags", {gt4, eq4, lt4}, ref_rel(int'(x4), int'(y4), 4, s));
            @(negedge clk);
        end

        // Randomized 8-bit compares; bias some toward shared high digits and equality.
        for (int t = 0; t < 300; t++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            case ($urandom_range(0, 3))
                0: y = x;
                1: y = {x[7:4], y[3:0]};
                2: y = {x[7:2], y[1:0]};
                default: ;
            endcase
            run_cmp(x, y, 1'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
